// File: rtl/piso_pkg.sv
// piso_pkg: shared types and helpers for the piso_shift_tx transmitter.
//   piso_state_e   : FSM state encoding (IDLE, SHIFT, PARITY)
//   PISO_DEF_WIDTH : default data word width
//   piso_frame_len : serial frame length in bits for a given width and parity setting
// Optional feature macro: PISO_PARITY_EN (adds a trailing even-parity bit).
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } piso_state_e;

   localparam int PISO_DEF_WIDTH = 8;

`ifdef PISO_PARITY_EN
   localparam bit PISO_PARITY_ON = 1'b1;
`else
   localparam bit PISO_PARITY_ON = 1'b0;
`endif

   function automatic int piso_frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if: load handshake and serial output bundle of piso_shift_tx.
//   din, load_valid   : parallel word offered by the source
//   load_ready        : transmitter accepts the word on a clock edge where
//                       load_valid && load_ready (no other transfer condition)
//   sout, sout_valid  : serial bit and its qualifier
//   frame_done, busy  : end-of-frame pulse and frame-in-progress flag
//   state_dbg         : FSM state, exposed for observation
// Modports: master = word source / serial sink, slave = transmitter.
interface piso_shift_tx_if
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_DEF_WIDTH
);
   logic [WIDTH-1:0] din;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             frame_done;
   logic             busy;
   piso_state_e      state_dbg;

   modport master (
      output din, load_valid,
      input  load_ready, sout, sout_valid, frame_done, busy, state_dbg
   );

   modport slave (
      input  din, load_valid,
      output load_ready, sout, sout_valid, frame_done, busy, state_dbg
   );
endinterface

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: frame bit counter for piso_shift_tx.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (highest priority)
//   zero_i     : load zero (start of frame / end of data bits)
//   inc_i      : increment by one
//   cnt_o      : current count, $clog2(WIDTH+1) bits
//   tc_o       : terminal count, high when cnt_o == WIDTH-1
module piso_bit_cnt #(
   parameter int WIDTH = 8,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          zero_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || zero_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out shift transmitter.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear_n  : synchronous active-low clear, discards any frame in flight
//   bus      : piso_shift_tx_if.slave (din/load_valid/load_ready handshake,
//              sout/sout_valid/frame_done/busy outputs, state_dbg)
// Parameters: WIDTH (>=2), LSB_FIRST (1 = bit 0 first, 0 = bit WIDTH-1 first).
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every
// frame and moves frame_done onto it.
module piso_shift_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = PISO_DEF_WIDTH,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear_n,
   piso_shift_tx_if.slave        bus
);

   localparam int CW = $clog2(WIDTH + 1);

   piso_state_e      state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [CW-1:0]    cnt;
   logic             cnt_tc;
   logic             in_shift;
   logic             last_cycle;
   logic             load_ready;
   logic             accept;
   logic             head_bit;
`ifdef PISO_PARITY_EN
   logic             parity_q;
`endif

   assign in_shift = (state_q == ST_SHIFT);
   assign head_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

   always_comb begin
      shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
   end

`ifdef PISO_PARITY_EN
   assign last_cycle = (state_q == ST_PARITY);
`else
   assign last_cycle = in_shift && cnt_tc;
`endif

   // Ready gates on reset_n and clear_n combinationally so neither a held
   // reset nor a clear cycle can accept a word.
   assign load_ready = reset_n && clear_n && ((state_q == ST_IDLE) || last_cycle);
   assign accept     = bus.load_valid && load_ready;

   piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
      .clk    (clk),
      .rst_n  (reset_n),
      .clr_i  (!clear_n),
      .zero_i (accept || (in_shift && cnt_tc)),
      .inc_i  (in_shift && !cnt_tc),
      .cnt_o  (cnt),
      .tc_o   (cnt_tc)
   );

   // accept can only be high in IDLE or the final frame cycle, so loading
   // ahead of the state case also covers the back-to-back reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (!clear_n) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (accept) begin
         state_q  <= ST_SHIFT;
         shreg_q  <= bus.din;
`ifdef PISO_PARITY_EN
         parity_q <= ^bus.din;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_IDLE;
            end
            ST_SHIFT: begin
               shreg_q <= shreg_d;
               if (cnt_tc) begin
`ifdef PISO_PARITY_EN
                  state_q <= ST_PARITY;
`else
                  state_q <= ST_IDLE;
`endif
               end
            end
            ST_PARITY: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.sout = 1'b0;
      if (in_shift) begin
         bus.sout = head_bit;
      end
`ifdef PISO_PARITY_EN
      else if (state_q == ST_PARITY) begin
         bus.sout = parity_q;
      end
`endif
   end

   assign bus.sout_valid = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
   assign bus.busy       = bus.sout_valid;
   assign bus.frame_done = last_cycle;
   assign bus.load_ready = load_ready;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
module tb_piso_shift_tx;
  import piso_pkg::*;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_n = 1'b1;
  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(W)) if_lsb ();
  piso_shift_tx_if #(.WIDTH(W)) if_msb ();

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_n (clear_n),
    .bus     (if_lsb.slave)
  );

  piso_shift_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_n (clear_n),
    .bus     (if_msb.slave)
  );

  // ---------------- scoreboard ----------------
  // One entry per expected serial cycle: {frame_done, sout}.
  logic [1:0] exp_q_lsb[$];
  logic [1:0] exp_q_msb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected serial frame for a word, straight from the bit-order rules.
  task automatic push_frame(input bit lane, input logic [W-1:0] w);
    logic [1:0] e;
    for (int i = 0; i < W; i++) begin
      e[0] = (lane == 1'b0) ? w[i] : w[W-1-i];
      e[1] = (i == W - 1) && !PAR;
      if (lane == 1'b0) exp_q_lsb.push_back(e);
      else exp_q_msb.push_back(e);
    end
    if (PAR) begin
      e = {1'b1, ^w};
      if (lane == 1'b0) exp_q_lsb.push_back(e);
      else exp_q_msb.push_back(e);
    end
  endtask

  task automatic read_lane(input bit lane, output logic [4:0] o);
    if (lane == 1'b0)
      o = {if_lsb.load_ready, if_lsb.busy, if_lsb.frame_done, if_lsb.sout_valid, if_lsb.sout};
    else
      o = {if_msb.load_ready, if_msb.busy, if_msb.frame_done, if_msb.sout_valid, if_msb.sout};
  endtask

  // Check one lane for the current cycle, then advance its model across the
  // coming clock edge.
  task automatic step_lane(input bit lane, input logic lv, input logic [W-1:0] d, input logic cn);
    logic [4:0] o;
    logic [1:0] e;
    bit has;
    bit exp_ready;
    string ln;
    ln = (lane == 1'b0) ? "lsb" : "msb";
    has = (lane == 1'b0) ? (exp_q_lsb.size() > 0) : (exp_q_msb.size() > 0);
    e = 2'b00;
    if (has) e = (lane == 1'b0) ? exp_q_lsb[0] : exp_q_msb[0];
    exp_ready = cn && (!has || e[1]);
    read_lane(lane, o);
    check({ln, " sout_valid"}, 32'(o[1]), 32'(has));
    check({ln, " sout"},       32'(o[0]), 32'(has ? e[0] : 1'b0));
    check({ln, " frame_done"}, 32'(o[2]), 32'(has && e[1]));
    check({ln, " busy"},       32'(o[3]), 32'(has));
    check({ln, " load_ready"}, 32'(o[4]), 32'(exp_ready));
    if (has) begin
      if (lane == 1'b0) void'(exp_q_lsb.pop_front());
      else void'(exp_q_msb.pop_front());
    end
    if (!cn) begin
      if (lane == 1'b0) exp_q_lsb.delete();
      else exp_q_msb.delete();
    end else if (lv && exp_ready) begin
      push_frame(lane, d);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic lv, input logic [W-1:0] d, input logic cn);
    @(negedge clk);
    if_lsb.load_valid = lv;
    if_msb.load_valid = lv;
    if_lsb.din = d;
    if_msb.din = d;
    clear_n = cn;
    #1;
    step_lane(1'b0, lv, d, cn);
    step_lane(1'b1, lv, d, cn);
  endtask

  task automatic check_all_zero(input string tag);
    logic [4:0] o;
    read_lane(1'b0, o);
    check({tag, " lsb outputs"}, 32'(o), 32'(0));
    read_lane(1'b1, o);
    check({tag, " msb outputs"}, 32'(o), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_lsb.load_valid = 1'b0;
    if_msb.load_valid = 1'b0;
    if_lsb.din = '0;
    if_msb.din = '0;

    // Reset held: everything low, including load_ready.
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single frame 0x3A, then idle long enough to see IDLE ready.
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 8'h3A, 1'b1);
    for (int i = 0; i < W + 4; i++) drive_cycle(1'b0, $urandom_range(0, 255), 1'b1);

    // Back-to-back: 0x0F offered on the final cycle of 0x3A.
    drive_cycle(1'b1, 8'h3A, 1'b1);
    for (int i = 0; i < W - 1 + int'(PAR); i++) drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < W + 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Parity-style words, and a busy-time load_valid that must be ignored.
    drive_cycle(1'b1, 8'h07, 1'b1);
    drive_cycle(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < W + 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Clear during bit 3 of 0xFF with a simultaneous load_valid.
    drive_cycle(1'b1, 8'hFF, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle during a frame.
    drive_cycle(1'b1, 8'hA5, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    if_lsb.load_valid = 1'b0;
    if_msb.load_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    exp_q_lsb.delete();
    exp_q_msb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  W'($urandom_range(0, 255)),
                  ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < W + 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
